// File: rtl/mdu_alu_sequencer.sv
// rtl/mdu_alu_sequencer.sv - multi-cycle MUL/DIV sequencer driving the shared ALU.
// Define SIGNED_MDU_EN to enable signed MULT/DIV (op[1]) with a sign-fix cycle.
module mdu_alu_sequencer #(
   parameter int         WIDTH   = 32,
   parameter logic [2:0] ALU_ADD = 3'b000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] alu_opA,
   output logic [WIDTH-1:0] alu_opB,
   output logic [2:0]       alu_ctrl,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_carry
);
   localparam int            CW   = $clog2(WIDTH);
   localparam int            W2   = 2 * WIDTH;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [2:0] {IDLE, SETUP, MUL_IT, DIV_IT, FIX, DONE} state_t;
   state_t state, state_nx;

   // acc/pq/md hold {acc,P,M} for multiply and {R,Q,D} for divide
   logic [WIDTH-1:0] acc, pq, md, neg_d, a_raw, mag_a, mag_b;
   logic [WIDTH-1:0] r_sh, mul_acc_n, mul_pq_n, div_acc_n, div_pq_n;
   logic [CW-1:0]    cnt;
   logic             last, take, sgn;

`ifdef SIGNED_MDU_EN
   logic s_a, s_b, is_div, neg_a, neg_b;
   assign neg_a = op[1] & src_a[WIDTH-1];
   assign neg_b = op[1] & src_b[WIDTH-1];
   assign mag_a = neg_a ? ~src_a + WIDTH'(1) : src_a;
   assign mag_b = neg_b ? ~src_b + WIDTH'(1) : src_b;

   always_ff @(posedge clk) begin
      if (rst) begin
         s_a <= 1'b0; s_b <= 1'b0; sgn <= 1'b0; is_div <= 1'b0; a_raw <= '0;
      end else if (state == IDLE && start) begin
         s_a <= neg_a; s_b <= neg_b; sgn <= op[1]; is_div <= op[0]; a_raw <= src_a;
      end
   end
`else
   logic unused_op;
   assign unused_op = op[1];
   assign sgn   = 1'b0;
   assign mag_a = src_a;
   assign mag_b = src_b;
   assign a_raw = pq;
`endif

   assign last      = (cnt == LAST);
   assign r_sh      = {acc[WIDTH-2:0], pq[WIDTH-1]};
   assign take      = acc[WIDTH-1] | alu_carry;
   assign mul_acc_n = {alu_carry, alu_result[WIDTH-1:1]};
   assign mul_pq_n  = {alu_result[0], pq[WIDTH-1:1]};
   assign div_acc_n = take ? alu_result : r_sh;
   assign div_pq_n  = {pq[WIDTH-2:0], take};

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = op[0] ? SETUP : MUL_IT;
         SETUP:   state_nx = (md == '0) ? DONE : DIV_IT;
         MUL_IT:  if (last) state_nx = sgn ? FIX : DONE;
         DIV_IT:  if (last) state_nx = sgn ? FIX : DONE;
         FIX:     state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy     = (state != IDLE);
      done     = (state == DONE);
      alu_ctrl = ALU_ADD;
      alu_opA  = '0;
      alu_opB  = '0;
      case (state)
         SETUP: if (md != '0) begin
            alu_opA = ~md;
            alu_opB = WIDTH'(1);
         end
         MUL_IT: begin
            alu_opA = acc;
            alu_opB = pq[0] ? md : '0;
         end
         DIV_IT: begin
            alu_opA = r_sh;
            alu_opB = neg_d;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hi <= '0; lo <= '0; acc <= '0; pq <= '0; md <= '0; neg_d <= '0; cnt <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               acc <= '0;
               pq  <= op[0] ? mag_a : mag_b;
               md  <= op[0] ? mag_b : mag_a;
            end
            SETUP: begin
               neg_d <= alu_result;
               if (md == '0) begin
                  hi <= a_raw;
                  lo <= '1;
               end
            end
            MUL_IT: begin
               acc <= mul_acc_n;
               pq  <= mul_pq_n;
               cnt <= cnt + CW'(1);
               if (last && !sgn) begin
                  hi <= mul_acc_n;
                  lo <= mul_pq_n;
               end
            end
            DIV_IT: begin
               acc <= div_acc_n;
               pq  <= div_pq_n;
               cnt <= cnt + CW'(1);
               if (last && !sgn) begin
                  hi <= div_acc_n;
                  lo <= div_pq_n;
               end
            end
`ifdef SIGNED_MDU_EN
            FIX: begin
               if (is_div) begin
                  lo <= (s_a ^ s_b) ? ~pq + WIDTH'(1) : pq;
                  hi <= s_a ? ~acc + WIDTH'(1) : acc;
               end else begin
                  {hi, lo} <= (s_a ^ s_b) ? ~{acc, pq} + W2'(1) : {acc, pq};
               end
            end
`endif
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mdu_alu_sequencer.sv
// tb/tb_mdu_alu_sequencer.sv - directed self-checking bench for mdu_alu_sequencer.
// Models the shared ALU as a 32-bit adder with carry-out.
module tb_mdu_alu_sequencer;
   logic        clk = 1'b0;
   logic        rst, start;
   logic [1:0]  op;
   logic [31:0] src_a, src_b;
   logic        busy, done;
   logic [31:0] hi, lo, alu_opA, alu_opB, alu_result;
   logic [2:0]  alu_ctrl;
   logic        alu_carry;

   int total = 0;
   int bad   = 0;
   logic [31:0] prev_hi, prev_lo;

   mdu_alu_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
      .busy(busy), .done(done), .hi(hi), .lo(lo), .alu_opA(alu_opA), .alu_opB(alu_opB),
      .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_carry(alu_carry)
   );

   assign {alu_carry, alu_result} = {1'b0, alu_opA} + {1'b0, alu_opB};

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Call at a negedge; returns at the negedge of the cycle after done.
   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int lat, input logic [31:0] ehi,
                         input logic [31:0] elo, input bit rp);
      int got_lat = 0;
      int busy_bad = 0;
      int ctrl_bad = 0;
      logic [31:0] ghi = '0;
      logic [31:0] glo = '0;
      op = o; src_a = a; src_b = b; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 1) begin
            check({tag, "_hold_hi"}, hi, prev_hi);
            check({tag, "_hold_lo"}, lo, prev_lo);
         end
         if (!busy) busy_bad++;
         if (alu_ctrl !== 3'b000) ctrl_bad++;
         if (rp && k == 5) begin start = 1'b1; src_a = 32'd9; end
         if (rp && k == 6) start = 1'b0;
         if (rp && k == lat) start = 1'b1;
         if (done) begin
            got_lat = k; ghi = hi; glo = lo;
            break;
         end
      end
      check({tag, "_latency"}, got_lat, lat);
      check({tag, "_hi"}, ghi, ehi);
      check({tag, "_lo"}, glo, elo);
      check({tag, "_busy_gaps"}, busy_bad, 0);
      check({tag, "_alu_ctrl"}, ctrl_bad, 0);
      @(negedge clk);
      start = 1'b0;
      check({tag, "_after_done"}, {busy, done}, 2'b00);
      check({tag, "_after_ops"}, {alu_opA, alu_opB}, 64'd0);
      prev_hi = ehi;
      prev_lo = elo;
   endtask

   initial begin
      int dones;
      rst = 1'b1; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
      prev_hi = '0; prev_lo = '0;
      repeat (3) @(negedge clk);
      check("reset_ctl", {busy, done}, 2'b00);
      check("reset_hilo", {hi, lo}, 64'd0);
      check("reset_ops", {alu_opA, alu_opB}, 64'd0);
      rst = 1'b0;

      run_op("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE, 32'h00000001, 1'b0);
      run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 34, 32'd2, 32'd14, 1'b0);
      run_op("divu_msb_3", 2'b01, 32'h80000000, 32'd3, 34, 32'd2, 32'h2AAAAAAA, 1'b0);
      run_op("divu_zero", 2'b01, 32'h12345678, 32'd0, 2, 32'h12345678, 32'hFFFFFFFF, 1'b0);
      run_op("multu_repulse", 2'b00, 32'd6, 32'd7, 33, 32'd0, 32'd42, 1'b1);
      run_op("back_to_back", 2'b01, 32'd100, 32'd7, 34, 32'd2, 32'd14, 1'b0);
`ifdef SIGNED_MDU_EN
      run_op("mult_neg", 2'b10, 32'hFFFFFFFD, 32'd5, 34, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
      run_op("div_neg", 2'b11, 32'hFFFFFFF9, 32'd2, 35, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
`else
      run_op("op10_as_multu", 2'b10, 32'hFFFFFFFD, 32'd5, 33, 32'h00000004, 32'hFFFFFFF1, 1'b0);
      run_op("op11_as_divu", 2'b11, 32'hFFFFFFF9, 32'd2, 34, 32'h00000001, 32'h7FFFFFFC, 1'b0);
`endif
      run_op("div_s_zero", 2'b11, 32'hFFFFFFFB, 32'd0, 2, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b0);

      // Reset in the middle of a divide
      op = 2'b01; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 1; k <= 10; k++) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_ctl", {busy, done}, 2'b00);
      check("rst_mid_hilo", {hi, lo}, 64'd0);
      rst = 1'b0;
      dones = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("rst_mid_no_done", dones, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mdu_alu_sequencer.md
Name: mdu_alu_sequencer

Overview:
- Multi-cycle multiply/divide unit for the MIPS datapath (MULTU/DIVU, optionally MULT/DIV) that owns no adder of its own.
- It drives the shared 32-bit ALU through 32 iterations: shift-add for multiply, non-restoring-free restoring divide for divide.
- Results go to HI/LO registers for the mfhi/mflo paths.
- It sits between the decode/execute stage (start/op) and the ALU operand/control inputs, and stalls the pipeline via busy.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported; iteration count equals WIDTH.
- ALU_ADD, 3'b000, ALU control code issued for every ALU use, since only ADD updates the ALU carry.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  request pulse; accepted only in IDLE
- op  in  2  00=MULTU, 01=DIVU, 10=MULT, 11=DIV; op[1] is meaningful only with SIGNED_MDU_EN
- src_a  in  32  multiplicand / dividend
- src_b  in  32  multiplier / divisor
- busy  out  1  high from the cycle after acceptance until done, inclusive
- done  out  1  one-cycle pulse; hi/lo valid from this cycle
- hi  out  32  MUL: product[63:32]; DIV: remainder
- lo  out  32  MUL: product[31:0]; DIV: quotient
- alu_opA  out  32  ALU operand A
- alu_opB  out  32  ALU operand B
- alu_ctrl  out  3  ALU control; always ALU_ADD
- alu_result  in  32  ALU out (combinational)
- alu_carry  in  1  ALU carry (valid for ADD)

Behaviour:
- States: IDLE, SETUP, MUL_IT, DIV_IT, FIX, DONE.
- Reset: state=IDLE; busy=0, done=0, hi=0, lo=0; iteration counter=0; alu_opA=alu_opB=0.
- In IDLE, and whenever the ALU is unused, alu_opA=alu_opB=0.
- Acceptance: start=1 in IDLE at edge E0 latches src_a, src_b and op. Cycle k means k cycles after E0.
- start while not IDLE is ignored; it is not queued.
- MULTU: acc=0, P=src_b, M=src_a; MUL_IT for cycles 1..32.
  - Per iteration: alu_opA=acc, alu_opB = P[0] ? M : 0.
  - Update {acc,P} <= {alu_carry, alu_result, P} >> 1.
  - DONE in cycle 33: done=1, hi=acc, lo=P.
- DIVU, divisor != 0:
  - SETUP in cycle 1: alu_opA=~src_b, alu_opB=1; store negD=alu_result.
  - DIV_IT for cycles 2..33, with R=0, Q=src_a initially. Per iteration:
    - R_sh={R[30:0],Q[31]}; msb=R[31].
    - alu_opA=R_sh, alu_opB=negD.
    - take = msb | alu_carry.
    - R <= take ? alu_result : R_sh; Q <= {Q[30:0],take}.
  - DONE in cycle 34: hi=R, lo=Q.
- DIVU, divisor == 0: SETUP goes directly to DONE (cycle 2) with lo=32'hFFFFFFFF, hi=src_a; the ALU is not driven.
- hi/lo update only on entering DONE; they hold their values otherwise, including across a new start, until the next DONE.
- DONE always returns to IDLE next cycle. A start in that IDLE cycle is accepted, so back-to-back throughput is one op per latency+1 cycles.
- Iteration counter counts 0..31; it wraps to 0 on exit and is never observed outside.
- rst mid-operation: returns to IDLE immediately, clears hi/lo; no done pulse.

Optional Feature:
- Macro: SIGNED_MDU_EN.
- With the macro defined:
  - op 10/11 latch |src_a|, |src_b| (internal two's-complement negate) and sign flags sA, sB.
  - The unsigned algorithm runs on the magnitudes, then FIX takes one extra cycle before DONE:
    - MULT: if sA^sB, negate the 64-bit product.
    - DIV: negate the quotient if sA^sB; negate the remainder if sA.
  - Latency becomes 34 for MULT and 35 for DIV.
  - Signed divide by zero behaves as unsigned (lo=32'hFFFFFFFF, hi=raw src_a), with no FIX.
- Without the macro: op[1] is ignored and 10/11 behave exactly as 00/01; FIX is never entered.

Test Plan:
- MULTU src_a=32'hFFFFFFFF, src_b=32'hFFFFFFFF -> done in cycle 33; hi=32'hFFFFFFFE, lo=32'h00000001; busy high in cycles 1..33; alu_ctrl=3'b000 throughout.
- DIVU src_a=100, src_b=7 -> done in cycle 34; lo=14, hi=2. DIVU 32'h80000000 / 3 -> lo=32'h2AAAAAAA, hi=2.
- DIVU src_b=0, src_a=32'h12345678 -> done in cycle 2; lo=32'hFFFFFFFF, hi=32'h12345678.
- MULTU 6*7 with start re-pulsed at cycles 5 and 33 -> one done in cycle 33 (hi=0, lo=42); start accepted in cycle 34 begins the next op.
- DIVU 100/7 with rst asserted in cycle 10 -> cycle 11: busy=0, done=0, hi=lo=0; no done pulse ever follows.
- SIGNED_MDU_EN: MULT -3*5 -> cycle 34: hi=32'hFFFFFFFF, lo=32'hFFFFFFF1. DIV -7/2 -> cycle 35: lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. Without the macro, op=10 on the same operands gives the MULTU result.
